// File: rtl/clock_divider_pkg.sv
`timescale 1ns/1ps
// clock_divider_pkg: shared constants and width helper for the clock divider.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package clock_divider_pkg;

    // Smallest legal division ratio; below this there is no low and high phase.
    localparam int CLKDIV_MIN_DIV = 2;

    // Counter width for a modulo-div counter, never narrower than one bit.
    function automatic int clkdiv_cnt_w(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clkdiv_mod_counter.sv
`timescale 1ns/1ps
// clkdiv_mod_counter: free-running modulo-MOD up counter with look-ahead next value.
// Latency: cnt updates on every clk rising edge; cnt_next is combinational from cnt.
// Backpressure: none, always counts; async active-low reset forces cnt to 0.
module clkdiv_mod_counter
    import clock_divider_pkg::*;
#(
    parameter int MOD = 2,
    parameter int W   = clkdiv_cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next
);

    // Terminal count; the counter wraps to zero after this value.
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_next;

    // Next value: wrap at the terminal count so cnt never reaches MOD.
    always_comb begin
        w_cnt_next = r_cnt + W'(1);
        if (r_cnt == LAST) begin
            w_cnt_next = '0;
        end
    end

    // Counter state; reset discards the current phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt      = r_cnt;
    assign cnt_next = w_cnt_next;

endmodule

// File: rtl/clock_divider.sv
`timescale 1ns/1ps
// clock_divider: divides clk by DIV into registered clk_out plus a tick on each clk_out rise.
// Latency: clk_out and tick are registered from the counter look-ahead; first rise LOW cycles after reset release.
// Backpressure: none, free-running. Macro CLOCK_DIVIDER_ODD_DUTY_EN adds a negedge helper for 50% duty at odd DIV.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out,
    output logic tick
);

    localparam int CNT_W = clkdiv_cnt_w(DIV);
    localparam int HIGH  = DIV / 2;
    localparam int LOW   = DIV - HIGH;

    // Counter value at which clk_out rises; it stays high until the wrap.
    localparam logic [CNT_W-1:0] LOW_V  = CNT_W'(LOW);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(DIV - 1);

    if (DIV < CLKDIV_MIN_DIV) begin : g_bad_div
        $error("clock_divider: DIV must be at least 2");
    end

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_clk_out;
    logic             r_tick;

    clkdiv_mod_counter #(
        .MOD (DIV),
        .W   (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .cnt      (w_cnt),
        .cnt_next (w_cnt_next)
    );

    // Compare against the look-ahead count so clk_out and tick line up with the counter edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_clk_out <= (w_cnt_next >= LOW_V);
            r_tick    <= (w_cnt_next == LOW_V);
        end
    end

    // The counter must never hold a value at or beyond DIV.
    a_cnt_range : assert property (@(posedge clk) disable iff (!reset) w_cnt <= LAST_V);

`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
    if ((DIV % 2) == 1) begin : g_odd_duty
        logic r_clk_half;

        // Half-cycle delayed copy stretches the high phase by half a clk for exact 50% duty.
        always_ff @(negedge clk or negedge reset) begin
            if (!reset) begin
                r_clk_half <= 1'b0;
            end else begin
                r_clk_half <= r_clk_out;
            end
        end

        assign clk_out = r_clk_out | r_clk_half;
    end else begin : g_even_duty
        assign clk_out = r_clk_out;
    end
`else
    assign clk_out = r_clk_out;
`endif

    assign tick = r_tick;

endmodule

// File: tb/tb_clock_divider.sv
`timescale 1ns/1ps
module tb_clock_divider;

`ifdef CLOCK_DIVIDER_ODD_DUTY_EN
    localparam bit ODD_EN = 1'b1;
`else
    localparam bit ODD_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    logic co20, tk20, co5, tk5, co2, tk2;

    int checks;
    int errors;
    int k;      // rising edges since reset release

    clock_divider #(.DIV(20)) u_d20 (.clk(clk), .reset(reset), .clk_out(co20), .tick(tk20));
    clock_divider #(.DIV(5))  u_d5  (.clk(clk), .reset(reset), .clk_out(co5),  .tick(tk5));
    clock_divider #(.DIV(2))  u_d2  (.clk(clk), .reset(reset), .clk_out(co2),  .tick(tk2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter of the reference: edges since release, zeroed while reset is held.
    always @(posedge clk or negedge reset) begin
        if (!reset) k = 0;
        else        k = k + 1;
    end

    // Low for the first div - div/2 positions of every period, high for the rest.
    function automatic logic ref_out(input int div, input int kk);
        return ((kk % div) >= (div - div / 2));
    endfunction

    function automatic logic ref_tick(input int div, input int kk);
        return ((kk % div) == (div - div / 2));
    endfunction

    // Just after a rising edge: in odd-duty mode the previous position still holds the output high.
    function automatic logic ref_out_early(input int div, input int kk);
        logic r;
        r = ref_out(div, kk);
        if (ODD_EN && (div % 2 == 1) && kk >= 1) r = r | ref_out(div, kk - 1);
        return r;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if ({co20, tk20, co5, tk5, co2, tk2} !== 6'b0) begin
                errors++;
                $display("FAIL reset_state got %b want 000000", {co20, tk20, co5, tk5, co2, tk2});
            end
        end
    endtask

    task automatic test_random_run(input int n);
        logic [5:0] exp_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            exp_v = {ref_out_early(20, k), ref_tick(20, k), ref_out_early(5, k), ref_tick(5, k),
                     ref_out_early(2, k), ref_tick(2, k)};
            checks++;
            if ({co20, tk20, co5, tk5, co2, tk2} !== exp_v) begin
                errors++;
                $display("FAIL run_posedge k=%0d got %b want %b", k, {co20, tk20, co5, tk5, co2, tk2}, exp_v);
            end
            @(negedge clk);
            #2;
            exp_v = {ref_out(20, k), ref_tick(20, k), ref_out(5, k), ref_tick(5, k),
                     ref_out(2, k), ref_tick(2, k)};
            checks++;
            if ({co20, tk20, co5, tk5, co2, tk2} !== exp_v) begin
                errors++;
                $display("FAIL run_negedge k=%0d got %b want %b", k, {co20, tk20, co5, tk5, co2, tk2}, exp_v);
            end
        end
    endtask

    task automatic test_timing();
        longint rise20[$], fall20[$], rise5[$], fall5[$];
        logic p20, p5;
        reset = 1'b0;
        @(negedge clk);
        #2;
        #20;
        reset = 1'b1;
        p20 = co20;
        p5  = co5;
        for (int i = 0; i < 130; i++) begin
            if (i % 2 == 0) @(posedge clk);
            else            @(negedge clk);
            #2;
            if (co20 && !p20) rise20.push_back($time);
            if (!co20 && p20) fall20.push_back($time);
            if (co5 && !p5)   rise5.push_back($time);
            if (!co5 && p5)   fall5.push_back($time);
            p20 = co20;
            p5  = co5;
        end
        checks++;
        if (rise20.size() < 2 || (rise20[1] - rise20[0]) != 200) begin
            errors++;
            $display("FAIL period20 got %0d rises, first gap %0d want 200", rise20.size(),
                     (rise20.size() < 2) ? 0 : rise20[1] - rise20[0]);
        end
        checks++;
        if (rise20.size() < 1 || fall20.size() < 1 || (fall20[0] - rise20[0]) != 100) begin
            errors++;
            $display("FAIL high20 got %0d want 100",
                     (rise20.size() < 1 || fall20.size() < 1) ? -1 : fall20[0] - rise20[0]);
        end
        checks++;
        if (rise5.size() < 2 || (rise5[1] - rise5[0]) != 50) begin
            errors++;
            $display("FAIL period5 got %0d want 50", (rise5.size() < 2) ? -1 : rise5[1] - rise5[0]);
        end
        checks++;
        if (rise5.size() < 1 || fall5.size() < 1 || (fall5[0] - rise5[0]) != (ODD_EN ? 25 : 20)) begin
            errors++;
            $display("FAIL high5 got %0d want %0d",
                     (rise5.size() < 1 || fall5.size() < 1) ? -1 : fall5[0] - rise5[0], ODD_EN ? 25 : 20);
        end
    endtask

    task automatic test_tick_count();
        int n20, n5, n2;
        n20 = 0; n5 = 0; n2 = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            n20 += int'(tk20);
            n5  += int'(tk5);
            n2  += int'(tk2);
        end
        checks++;
        if (n20 != 3 || n5 != 12 || n2 != 30) begin
            errors++;
            $display("FAIL tick_count got %0d/%0d/%0d want 3/12/30", n20, n5, n2);
        end
    endtask

    task automatic test_div2_toggle();
        logic prev;
        @(posedge clk);
        #2;
        prev = co2;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (co2 !== ~prev || tk2 !== co2) begin
                errors++;
                $display("FAIL div2_toggle got clk_out=%b tick=%b want clk_out=%b tick=%b", co2, tk2, ~prev, ~prev);
            end
            prev = co2;
        end
    endtask

    task automatic test_mid_reset();
        int n;
        for (int i = 0; i < 40 && (k % 20) != 15; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (co20 !== 1'b1 || (k % 20) != 15) begin
            errors++;
            $display("FAIL mid_reset_pre got clk_out=%b phase=%0d want 1 phase 15", co20, k % 20);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({co20, tk20, co5, tk5, co2, tk2} !== 6'b0 || u_d20.w_cnt !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_async got outs=%b cnt=%0d want 000000 cnt 0",
                     {co20, tk20, co5, tk5, co2, tk2}, u_d20.w_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if ({tk20, tk5, tk2} !== 3'b0) begin
                errors++;
                $display("FAIL tick_in_reset got %b want 000", {tk20, tk5, tk2});
            end
        end
        release_reset();
        n = 0;
        while (co20 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL first_rise_after_reset got %0d cycles want 10", n);
        end
    endtask

    task automatic test_random_resets();
        int hold;
        for (int r = 0; r < 6; r++) begin
            test_random_run($urandom_range(5, 60));
            @(posedge clk);
            #($urandom_range(1, 8));
            reset = 1'b0;
            #1;
            checks++;
            if ({co20, tk20, co5, tk5, co2, tk2} !== 6'b0) begin
                errors++;
                $display("FAIL random_reset_async got %b want 000000", {co20, tk20, co5, tk5, co2, tk2});
            end
            hold = $urandom_range(1, 4);
            repeat (hold) @(posedge clk);
            release_reset();
        end
        test_random_run(25);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        test_reset();
        release_reset();
        test_random_run(45);
        test_tick_count();
        test_div2_toggle();
        test_mid_reset();
        test_random_run(30);
        test_timing();
        test_random_resets();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_divider.md
# clock_divider

Parameterised synchronous clock divider producing a divided clock `clk_out` with period `DIV` input cycles, plus a one-cycle `tick` strobe aligned to each rising edge of `clk_out`. It sits beside the system clock generator and feeds slow peripheral logic (display scan, debouncers, blinkers). All state is clocked by `clk`. The only exception is the optional odd-duty helper flop.

## Interface
- `DIV`, default 2: division ratio. Integer, `DIV >= 2`. A smaller value is an elaboration error (`$error`).
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: **asynchronous, active-low reset (asserted when 0)**.
- `clk_out` output, 1 bit: divided clock, registered.
- `tick` output, 1 bit: one-`clk`-cycle strobe, high in the cycle in which `clk_out` has just risen.

## Operation
- Local constants:
  - `CNT_W = $clog2(DIV)`.
  - `HIGH = DIV/2` (floor).
  - `LOW = DIV - HIGH`.
- Counter `cnt` is `CNT_W` bits.
  - On each `clk` rising edge, `cnt <= (cnt == DIV-1) ? 0 : cnt + 1`.
  - The counter wraps modulo `DIV` and never holds a value ≥ `DIV`.
- `clk_out <= (cnt_next >= LOW)`, registered.
  - `clk_out` is low for `LOW` cycles, then high for `HIGH` cycles, repeating.
- `tick <= (cnt_next == LOW)`, registered.
  - `tick` is exactly one cycle wide, once per `DIV` cycles.
- Reset asserted (`reset == 0`):
  - `cnt = 0`, `clk_out = 0`, `tick = 0` immediately, without waiting for a clock edge.
  - Reset mid-period discards the phase. After release, counting restarts from 0.
- Even `DIV`: 50 % duty. Odd `DIV` with the configuration macro undefined: high time is `(DIV-1)/2` cycles.

## Timing
- Edge k after reset release: `cnt = k mod DIV`.
- `clk_out` rises at edge `LOW`, `LOW+DIV`, …; it falls at edge `DIV`, `2·DIV`, ….
- `tick` is high for the cycle following each `clk_out` rising edge. It is driven from the same edge, so it has zero latency relative to `clk_out`.
- First `clk_out` rise after release: `LOW` input cycles.
- Reset release is synchronised by the first rising edge following deassertion. Deassertion coincident with an edge counts that edge as edge 0.
- No combinational path from `reset` or `clk` to the outputs, except in the odd-duty mode below.

## Configuration
- Macro `CLOCK_DIVIDER_ODD_DUTY_EN`.
- **Defined, odd `DIV`:**
  - A helper flop on the falling edge of `clk` samples the posedge `clk_out` register.
  - The output is the OR of the helper and the posedge register.
  - High time extends by half a cycle to `DIV/2` exactly, giving 50 % duty.
  - The helper is also reset asynchronously to 0.
  - `tick` is unchanged.
- **Defined, even `DIV`:** no effect.
- **Undefined:** no negedge logic exists; the duty cycle follows the floor rule above.

## Structure
- Package `clock_divider_pkg`:
  - function `clkdiv_cnt_w(int div)` returning `$clog2(div)`, with a minimum of 1;
  - constant `CLKDIV_MIN_DIV = 2`.
- Sub-module `clkdiv_mod_counter`, parameterised by `MOD`:
  - outputs `cnt` and `cnt_next`;
  - async active-low reset.
- The top module adds the compare registers and the optional negedge helper.

## Test plan
- **`DIV=20`, 10 ns `clk`:** hold `reset=0` for 20 ns, then release.
  - `clk_out` rises 100 ns after the first edge, falls at 200 ns.
  - Period 200 ns, high 100 ns, over 500 ns.
- **`DIV=20`:** `tick` is high exactly once per 20 cycles, coincident with each `clk_out` rise. It is never high during reset.
- **Reset mid-period (`DIV=20`, `clk_out=1` at cycle 15):** pull `reset` low.
  - `clk_out`, `tick` and `cnt` go to 0 immediately.
  - After release, the first rise occurs after 10 cycles.
- **`DIV=5`, macro undefined:** `clk_out` is low 3 cycles, high 2 cycles, period 5 cycles.
- **`DIV=5`, `CLOCK_DIVIDER_ODD_DUTY_EN` defined:** `clk_out` is high 2.5 cycles (25 ns at 10 ns `clk`), period 50 ns.
- **`DIV=2`:** `clk_out` toggles every edge, giving a 20 ns period at 10 ns `clk`; `tick` is high every other cycle.
